// File: rtl/nonce_collector_pkg.sv
// Shared types and helpers for the nonce collector.
//   state_t           : block FSM states (IDLE, SCAN, DONE)
//   MAX_CORES         : widest hit vector the helper functions accept
//   lowest_set_index  : priority encoder, lowest set bit wins
//   popcount          : number of set bits
// Size-dependent localparams (TOTAL, CNT_W, IDX_W) live in the top module,
// because they derive from its parameters.
package nonce_collector_pkg;

  localparam int MAX_CORES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scans from the top down so that the last match, which is the lowest index, sticks.
  function automatic int lowest_set_index(input logic [MAX_CORES-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int popcount(input logic [MAX_CORES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CORES; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/nonce_collector_if.sv
// Ready/valid result channel between the nonce collector and its consumer.
//   res_valid_o : head entry valid (collector -> consumer)
//   res_nonce_o : head entry nonce (collector -> consumer)
//   res_ready_i : consumer accepts head (consumer -> collector)
interface nonce_collector_if #(
  parameter int NONCE_W = 32
);
  logic               res_valid_o;
  logic [NONCE_W-1:0] res_nonce_o;
  logic               res_ready_i;

  modport master (output res_valid_o, output res_nonce_o, input res_ready_i);
  modport slave  (input res_valid_o, input res_nonce_o, output res_ready_i);
endinterface

// File: rtl/nonce_collector_fifo.sv
// result_fifo: DATA_W x DEPTH ready/valid FIFO with synchronous flush.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   flush    : empties the FIFO; a push in the same cycle becomes the only entry
//   push,din : write request and data (ignored when full unless popping)
//   pop      : read request (ignored when empty)
//   dout     : head entry, forced to 0 while empty
//   full     : DEPTH entries held
//   empty    : no entries held
module result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;
  logic              wr_en;
  logic [PW-1:0]     wr_addr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign wr_en   = flush ? push : do_push;
  assign wr_addr = flush ? '0 : wr_ptr;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      cnt    <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

endmodule

// File: rtl/nonce_collector.sv
// nonce_collector: counts batches of NUM_CORES hit flags per block, turns the
// winning core of each hit batch into an absolute nonce, queues it in a
// ready/valid FIFO and flags the end of the block with a one-cycle summary.
//   clk, rst       : clock, asynchronous active-high reset
//   newblock_i     : start a new block (any state), latches start_nonce_i
//   start_nonce_i  : first nonce of the block
//   valid_i, hit_i : one batch of per-core hit flags (bit k = core k)
//   res            : result channel (res_valid_o / res_nonce_o / res_ready_i)
//   done_o         : one-cycle pulse when the block finishes
//   found_o        : hit batches counted this block (saturating)
//   overflow_o     : a hit was dropped because the FIFO was full
//   multi_o        : some batch had more than one hit bit set
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int NUM_CORES     = 10,
  parameter int BROADCAST_CNT = 100,
  parameter int NONCE_W       = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int FIRST_ONLY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newblock_i,
  input  logic [NONCE_W-1:0]   start_nonce_i,
  input  logic                 valid_i,
  input  logic [NUM_CORES-1:0] hit_i,
  nonce_collector_if.master    res,
  output logic                 done_o,
  output logic [$clog2(NUM_CORES*BROADCAST_CNT+1)-1:0] found_o,
  output logic                 overflow_o,
  output logic                 multi_o
);
  localparam int TOTAL = NUM_CORES * BROADCAST_CNT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int BW    = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               in_scan;

  logic [NONCE_W-1:0] start_q;
  logic [NONCE_W-1:0] offset_q;
  logic [BW-1:0]      bcnt_q;
  logic [CNT_W-1:0]   found_q;
  logic               ovf_q;
  logic               multi_q;

  logic               accept;
  logic               any_hit;
  logic               multi_hit;
  logic [BW-1:0]      b_eff;
  logic               last_batch;
  logic               term;
  logic [NONCE_W-1:0] base;
  logic [NONCE_W-1:0] off;
  logic [IDX_W-1:0]   win_idx;
  logic [NONCE_W-1:0] nonce;
  logic [CNT_W-1:0]   found_base;
  logic [CNT_W-1:0]   found_nxt;

  logic               push;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;

  // ---- decode stage: batch acceptance, winner and nonce ----
  // A newblock_i batch is batch 0 of the new block, so the block-relative
  // values are taken from the inputs instead of the stale registers.
  assign accept     = valid_i && (newblock_i || in_scan);
  assign any_hit    = |hit_i;
  assign multi_hit  = popcount(MAX_CORES'(hit_i)) > 1;
  assign b_eff      = newblock_i ? '0 : bcnt_q;
  assign last_batch = (b_eff == BW'(BROADCAST_CNT - 1));
  assign term       = accept && (last_batch || ((FIRST_ONLY != 0) && any_hit));
  assign base       = newblock_i ? start_nonce_i : start_q;
  assign off        = newblock_i ? '0 : offset_q;
  assign win_idx    = IDX_W'(lowest_set_index(MAX_CORES'(hit_i)));
  assign nonce      = base + off + NONCE_W'(win_idx);

  assign found_base = newblock_i ? '0 : found_q;
  assign found_nxt  = (accept && any_hit && (found_base != CNT_W'(TOTAL)))
                      ? found_base + CNT_W'(1) : found_base;

  assign push = accept && any_hit;
  assign pop  = res.res_valid_o && res.res_ready_i;
  // A flush empties the FIFO, so a push alongside newblock_i never drops.
  assign drop = push && fifo_full && !pop && !newblock_i;

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (newblock_i) begin
      state_nxt = term ? ST_DONE : ST_SCAN;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_SCAN: state_nxt = term ? ST_DONE : ST_SCAN;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    done_o  = 1'b0;
    in_scan = 1'b0;
    case (state)
      ST_SCAN: in_scan = 1'b1;
      ST_DONE: done_o  = 1'b1;
      default: ;
    endcase
  end

  // ---- block bookkeeping stage (control) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      found_q <= '0;
      ovf_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      if (newblock_i || accept) bcnt_q <= accept ? b_eff + BW'(1) : '0;
      found_q <= found_nxt;
      ovf_q   <= (newblock_i ? 1'b0 : ovf_q) | drop;
      multi_q <= (newblock_i ? 1'b0 : multi_q) | (accept && multi_hit);
    end
  end

  // b*NUM_CORES kept as a running sum to avoid a multiplier.
  always_ff @(posedge clk) begin
    if (newblock_i) start_q <= start_nonce_i;
    if (newblock_i || accept) offset_q <= accept ? off + NONCE_W'(NUM_CORES) : '0;
  end

  // ---- result queue stage ----
  result_fifo #(
    .DATA_W (NONCE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (newblock_i),
    .push  (push),
    .din   (nonce),
    .pop   (pop),
    .dout  (res.res_nonce_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res.res_valid_o = !fifo_empty;
  assign found_o         = found_q;
  assign overflow_o      = ovf_q;
  assign multi_o         = multi_q;

endmodule
